// File: rtl/str_byte_stream_rx.sv
// Receive-side byte stream endpoint: valid/ready input, small FIFO, valid/ready output,
// accepted-byte counter and sticky overflow flag for pushes attempted while full.
module str_byte_stream_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_WIDTH-1:0]         byte_count,
    output logic                         overflow,
    input  logic                         clr_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  push_c, pop_c;

    // Handshake decode from registered occupancy only; no same-cycle pass-through when full.
    assign in_ready   = (level_q != LVL_W'(DEPTH));
    assign out_valid  = (level_q != LVL_W'(0));
    assign out_data   = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign byte_count = cnt_q;
    assign overflow   = ovf_q;

    always_comb begin
        push_c   = in_valid && in_ready;
        pop_c    = out_valid && out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d    = cnt_q + CNT_WIDTH'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_c && !push_c) begin
            level_d = level_q - LVL_W'(1);
        end

        // A new drop outranks a simultaneous clear.
        if (in_valid && !in_ready) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            if (push_c) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end
    end

endmodule
